// File: rtl/clk_div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : clk_div_pkg                                            |
// | Desc     : shared state type, limits and divisor clamp helper     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic [31:0] MIN_DIV = 32'd2;

   // Ratios below two cannot produce a high and a low phase.
   function automatic logic [31:0] clamp_div(input logic [31:0] n);
      return (n < MIN_DIV) ? MIN_DIV : n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : clk_div_counter                                        |
// | Desc     : period counter with terminal count and divisor load    |
// |            that only lands on a period boundary or while idle     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module clk_div_counter
   import clk_div_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_run,
   input  logic             i_load_req,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_tc,
   output logic             o_loaded,
   output logic [WIDTH-1:0] o_cnt_next,
   output logic [WIDTH-1:0] o_div_next
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div;
   logic             w_tc;
   logic             w_loaded;

   assign w_tc       = (r_cnt == r_div - WIDTH'(1));
   assign w_loaded   = i_load_req && (w_tc || !i_run);
   assign o_tc       = w_tc;
   assign o_loaded   = w_loaded;
   assign o_cnt_next = (i_run && !w_tc) ? r_cnt + WIDTH'(1) : '0;
   assign o_div_next = w_loaded ? i_load_val : r_div;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_div <= WIDTH'(DEFAULT_DIV);
      end else begin
         r_cnt <= o_cnt_next;
         r_div <= o_div_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : clk_div_prog                                           |
// | Desc     : programmable glitch-free clock divider with tick/ack;  |
// |            quadrature output enabled by CLK_DIV_PHASE90_EN        |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic             clk_out,
   output logic             tick,
   output logic             clk_q
);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_pending;
   logic             r_pending_valid;
   logic             r_clk_out;
   logic             r_tick;
   logic             r_div_ack;

   logic             w_counting;
   logic             w_tc;
   logic             w_loaded;
   logic             w_load_req;
   logic             w_active_next;
   logic [WIDTH-1:0] w_div_in_clamped;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_cnt_next;
   logic [WIDTH-1:0] w_div_next;
   logic [WIDTH-1:0] w_half_next;

   assign w_counting       = (r_state != IDLE);
   assign w_div_in_clamped = WIDTH'(clamp_div(32'(div_in)));

   // A load arriving on the wrap edge bypasses the pending register.
   assign w_load_req = r_pending_valid || (w_counting && div_load);
   assign w_load_val = (w_counting && div_load) ? w_div_in_clamped : r_pending;

   clk_div_counter #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .i_run      (w_counting),
      .i_load_req (w_load_req),
      .i_load_val (w_load_val),
      .o_tc       (w_tc),
      .o_loaded   (w_loaded),
      .o_cnt_next (w_cnt_next),
      .o_div_next (w_div_next)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (en) w_state_next = RUN;
         RUN:     if (!en) w_state_next = w_tc ? IDLE : STOP;
         STOP: begin
            if (en)        w_state_next = RUN;
            else if (w_tc) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_active_next = (w_state_next != IDLE);
   assign w_half_next   = w_div_next - (w_div_next >> 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_pending       <= '0;
         r_pending_valid <= 1'b0;
         r_clk_out       <= 1'b0;
         r_tick          <= 1'b0;
         r_div_ack       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (div_load && !(w_counting && w_loaded)) begin
            r_pending       <= w_div_in_clamped;
            r_pending_valid <= 1'b1;
         end else if (w_loaded) begin
            r_pending_valid <= 1'b0;
         end
         r_clk_out <= w_active_next && (w_cnt_next < w_half_next);
         r_tick    <= w_active_next && (w_cnt_next == w_div_next - WIDTH'(1));
         r_div_ack <= w_loaded;
      end
   end

   assign clk_out = r_clk_out;
   assign tick    = r_tick;
   assign div_ack = r_div_ack;

`ifdef CLK_DIV_PHASE90_EN
   logic [WIDTH-1:0] w_quarter_next;
   logic [WIDTH-1:0] w_qpos_next;
   logic             r_clk_q;

   // (cnt - Q) mod N without leaving the counter width.
   assign w_quarter_next = w_div_next >> 2;
   assign w_qpos_next    = (w_cnt_next >= w_quarter_next)
                         ? w_cnt_next - w_quarter_next
                         : w_cnt_next + (w_div_next - w_quarter_next);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_clk_q <= 1'b0;
      else       r_clk_q <= w_active_next && (w_qpos_next < w_half_next);
   end

   assign clk_q = r_clk_q;
`else
   assign clk_q = 1'b0;
`endif

endmodule
`default_nettype wire
